// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared types and constants for the clock set-mode controller
package clock_set_ctrl_pkg;

  localparam int NUM_KEYS = 4;
  localparam int KEY_W    = 2;

  localparam logic [KEY_W-1:0] KEY_MIN_DEC = 2'd0;
  localparam logic [KEY_W-1:0] KEY_MIN_INC = 2'd1;
  localparam logic [KEY_W-1:0] KEY_HR_DEC  = 2'd2;
  localparam logic [KEY_W-1:0] KEY_HR_INC  = 2'd3;

  localparam int DEF_BLINK_HALF    = 25_000_000;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 12_500_000;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    SET_IDLE   = 2'd1,
    SET_HOLD   = 2'd2,
    SET_REPEAT = 2'd3
  } state_t;

  // Lowest set bit wins when several keys go down in the same cycle.
  function automatic logic [KEY_W-1:0] lowest_key(input logic [NUM_KEYS-1:0] v);
    lowest_key = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_key = KEY_W'(i);
    end
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key_sync_edge.sv
// rtl/clock_set_ctrl_key_sync_edge.sv - 2-flop key synchronizer with press-edge detect
module key_sync_edge
  import clock_set_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] held,
  output logic [NUM_KEYS-1:0] press
);

  logic [NUM_KEYS-1:0] meta;
  logic [NUM_KEYS-1:0] sync;
  logic [NUM_KEYS-1:0] prev;

  // Reset to "released" so a key held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '1;
      sync <= '1;
      prev <= '1;
    end else begin
      meta <= key;
      sync <= meta;
      prev <= sync;
    end
  end

  assign held  = ~sync;
  assign press = prev & ~sync;

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - set-mode FSM: key press/hold/auto-repeat strobes and display blink
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int BLINK_HALF    = DEF_BLINK_HALF,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                CLOCK_50,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic                SW_SET,
  output logic                set_mode,
  output logic                run_en,
  output logic                cmd_min_dec,
  output logic                cmd_min_inc,
  output logic                cmd_hr_dec,
  output logic                cmd_hr_inc,
  output logic                cmd_sec_clr,
  output logic                blank
);

  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW     = (HR_MAX > 1) ? $clog2(HR_MAX) : 1;
  localparam int BW     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_HALF - 1);

  logic [NUM_KEYS-1:0] held;
  logic [NUM_KEYS-1:0] press;

  key_sync_edge u_key_sync (
    .clk   (CLOCK_50),
    .reset (RESET),
    .key   (KEY),
    .held  (held),
    .press (press)
  );

  logic sw_meta, sw_sync;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sw_meta <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      sw_meta <= SW_SET;
      sw_sync <= sw_meta;
    end
  end

  state_t              state, state_n;
  logic [KEY_W-1:0]    key_idx, key_idx_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [NUM_KEYS-1:0] strobe_n;
  logic [BW-1:0]       blink_cnt, blink_cnt_n;
  logic                phase, phase_n;

  always_comb begin
    state_n   = state;
    key_idx_n = key_idx;
    cnt_n     = cnt;
    strobe_n  = '0;
    case (state)
      RUN: begin
        cnt_n = '0;
        if (sw_sync) state_n = SET_IDLE;
      end
      SET_IDLE: begin
        cnt_n = '0;
        if (!sw_sync) begin
          state_n = RUN;
        end else if (|press) begin
          key_idx_n = lowest_key(press);
          strobe_n  = 4'b0001 << key_idx_n;
          state_n   = SET_HOLD;
        end
      end
      SET_HOLD: begin
        if (!sw_sync) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (!held[key_idx]) begin
          state_n = SET_IDLE;
          cnt_n   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_n  = SET_REPEAT;
          cnt_n    = '0;
          strobe_n = 4'b0001 << key_idx;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SET_REPEAT: begin
        if (!sw_sync) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (!held[key_idx]) begin
          state_n = SET_IDLE;
          cnt_n   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n    = '0;
          strobe_n = 4'b0001 << key_idx;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = '0;
      end
    endcase
  end

  // Blink is parked at "visible" whenever RUN is involved, so set mode always opens lit.
  always_comb begin
    blink_cnt_n = blink_cnt;
    phase_n     = phase;
    if (state == RUN || state_n == RUN) begin
      blink_cnt_n = '0;
      phase_n     = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_n = '0;
      phase_n     = ~phase;
    end else begin
      blink_cnt_n = blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state       <= RUN;
      key_idx     <= KEY_MIN_DEC;
      cnt         <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b1;
      set_mode    <= 1'b0;
      run_en      <= 1'b1;
      blank       <= 1'b0;
      cmd_min_dec <= 1'b0;
      cmd_min_inc <= 1'b0;
      cmd_hr_dec  <= 1'b0;
      cmd_hr_inc  <= 1'b0;
      cmd_sec_clr <= 1'b0;
    end else begin
      state       <= state_n;
      key_idx     <= key_idx_n;
      cnt         <= cnt_n;
      blink_cnt   <= blink_cnt_n;
      phase       <= phase_n;
      set_mode    <= (state_n != RUN);
      run_en      <= (state_n == RUN);
      blank       <= (state_n != RUN) & ~phase_n;
      cmd_min_dec <= strobe_n[KEY_MIN_DEC];
      cmd_min_inc <= strobe_n[KEY_MIN_INC];
      cmd_hr_dec  <= strobe_n[KEY_HR_DEC];
      cmd_hr_inc  <= strobe_n[KEY_HR_INC];
      cmd_sec_clr <= strobe_n[KEY_MIN_DEC] | strobe_n[KEY_MIN_INC];
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - scoreboard bench for clock_set_ctrl
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       RESET;
  logic [3:0] KEY;
  logic       SW_SET;
  logic       set_mode, run_en, blank;
  logic       cmd_min_dec, cmd_min_inc, cmd_hr_dec, cmd_hr_inc, cmd_sec_clr;

  clock_set_ctrl #(
    .BLINK_HALF    (5),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .CLOCK_50    (clk),
    .RESET       (RESET),
    .KEY         (KEY),
    .SW_SET      (SW_SET),
    .set_mode    (set_mode),
    .run_en      (run_en),
    .cmd_min_dec (cmd_min_dec),
    .cmd_min_inc (cmd_min_inc),
    .cmd_hr_dec  (cmd_hr_dec),
    .cmd_hr_inc  (cmd_hr_inc),
    .cmd_sec_clr (cmd_sec_clr),
    .blank       (blank)
  );

  always #5 clk = ~clk;

  // {sec_clr, hr_inc, hr_dec, min_inc, min_dec}
  localparam logic [4:0] E_MIN_DEC = 5'b10001;
  localparam logic [4:0] E_MIN_INC = 5'b10010;
  localparam logic [4:0] E_HR_DEC  = 5'b00100;
  localparam logic [4:0] E_HR_INC  = 5'b01000;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   blink_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input int c, input logic [4:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  function automatic logic exp_blank(input int c);
    return (((c - blink_start) / 5) % 2) == 1;
  endfunction

  // Monitor: every strobe must match the head of the queue in cycle and value.
  always @(negedge clk) begin
    logic [4:0] obs;
    obs = {cmd_sec_clr, cmd_hr_inc, cmd_hr_dec, cmd_min_inc, cmd_min_dec};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_strobe: expected %05b at cycle %0d", q[0].v, q[0].cyc);
      void'(q.pop_front());
    end
    if (obs != 5'b0) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("strobe_value", 32'(obs), 32'(q[0].v));
        void'(q.pop_front());
      end else begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe at cycle %0d: got %05b expected 00000", cyc, obs);
      end
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      tests++;
      fails++;
      $display("FAIL missed_strobe: got 00000 expected %05b at cycle %0d", q[0].v, cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    int p;
    int s;
    RESET  = 1'b1;
    KEY    = 4'hF;
    SW_SET = 1'b0;
    tick(3);
    chk("rst_set_mode", 32'(set_mode), 32'd0);
    chk("rst_run_en",   32'(run_en),   32'd1);
    chk("rst_blank",    32'(blank),    32'd0);
    RESET = 1'b0;
    tick(2);

    // Presses in RUN are ignored.
    KEY[1] = 1'b0;
    tick(3);
    KEY[1] = 1'b1;
    tick(10);
    chk("run_run_en",   32'(run_en),   32'd1);
    chk("run_blank",    32'(blank),    32'd0);
    chk("run_set_mode", 32'(set_mode), 32'd0);

    // Enter set mode; blink starts visible and toggles every 5 cycles.
    SW_SET = 1'b1;
    s = cyc;
    blink_start = s + 3;
    wait_to(s + 3);
    chk("set_mode_on", 32'(set_mode), 32'd1);
    chk("set_run_en",  32'(run_en),   32'd0);
    chk("blink_c0",    32'(blank),    32'd0);
    wait_to(s + 7);
    chk("blink_c4",    32'(blank),    32'd0);
    wait_to(s + 8);
    chk("blink_c5",    32'(blank),    32'd1);
    wait_to(s + 12);
    chk("blink_c9",    32'(blank),    32'd1);
    wait_to(s + 13);
    chk("blink_c10",   32'(blank),    32'd0);

    // Single short press of min+.
    p = cyc;
    push(p + 3, E_MIN_INC);
    KEY[1] = 1'b0;
    tick(3);
    KEY[1] = 1'b1;
    tick(10);
    chk("blink_after_key", 32'(blank), 32'(exp_blank(cyc)));

    // hr+ held through hold and repeat, released before the next repeat.
    p = cyc;
    push(p + 3,  E_HR_INC);
    push(p + 11, E_HR_INC);
    push(p + 15, E_HR_INC);
    push(p + 19, E_HR_INC);
    push(p + 23, E_HR_INC);
    push(p + 27, E_HR_INC);
    KEY[3] = 1'b0;
    tick(28);
    KEY[3] = 1'b1;
    tick(12);

    // Simultaneous min- and hr-: min- wins, later hr- re-press is ignored.
    p = cyc;
    push(p + 3, E_MIN_DEC);
    KEY = 4'b1010;
    tick(4);
    KEY[2] = 1'b1;
    tick(2);
    KEY[2] = 1'b0;
    tick(1);
    KEY[0] = 1'b1;
    tick(2);
    KEY[2] = 1'b1;
    tick(12);
    chk("blink_after_keys", 32'(blank), 32'(exp_blank(cyc)));

    // hr- into repeat, then leave set mode: the next repeat is dropped.
    p = cyc;
    push(p + 3,  E_HR_DEC);
    push(p + 11, E_HR_DEC);
    push(p + 15, E_HR_DEC);
    KEY[2] = 1'b0;
    tick(15);
    SW_SET = 1'b0;
    tick(5);
    chk("exit_set_mode", 32'(set_mode), 32'd0);
    chk("exit_blank",    32'(blank),    32'd0);
    chk("exit_run_en",   32'(run_en),   32'd1);
    KEY[2] = 1'b1;
    tick(10);

    // Reset during repeat, key still held afterwards: silent until re-pressed.
    SW_SET = 1'b1;
    tick(6);
    p = cyc;
    push(p + 3,  E_MIN_INC);
    push(p + 11, E_MIN_INC);
    push(p + 15, E_MIN_INC);
    KEY[1] = 1'b0;
    tick(16);
    RESET = 1'b1;
    tick(2);
    chk("midrst_set_mode", 32'(set_mode), 32'd0);
    chk("midrst_run_en",   32'(run_en),   32'd1);
    chk("midrst_blank",    32'(blank),    32'd0);
    RESET = 1'b0;
    tick(12);
    chk("post_rst_set_mode", 32'(set_mode), 32'd1);
    KEY[1] = 1'b1;
    tick(5);
    push(cyc + 3, E_MIN_INC);
    KEY[1] = 1'b0;
    tick(3);
    KEY[1] = 1'b1;
    tick(12);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
